// File: rtl/gx4000_cpr_loader.sv
// CPR (RIFF "AMS!") cartridge image parser: strips RIFF framing from the ioctl
// download stream and turns each "cbNN" chunk into writes to 16 KB bank NN.
module gx4000_cpr_loader #(
  parameter int MAX_BANKS  = 32,
  parameter int BANK_BYTES = 16384
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        cart_download,
  output logic [24:0] cart_addr,
  output logic [7:0]  cart_data,
  output logic        cart_wr,
  output logic        load_done,
  output logic        load_error,
  output logic [2:0]  error_code,
  output logic [5:0]  bank_count,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    IDLE, RIFF_ID, RIFF_LEN, FORM, CHK_ID, CHK_LEN, DATA, SKIP, PAD, ERROR
  } state_t;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [31:0] hdr, hdr_n;
  logic [31:0] chk_id, chk_id_n;
  logic [31:0] chk_len, chk_len_n;
  logic [31:0] remain, remain_n;
  logic [13:0] offset, offset_n;
  logic [4:0]  bank, bank_n;
  logic [24:0] exp_addr, exp_n;
  logic [31:0] seen;
  logic        chunk_seen, chunk_seen_n;
  logic        dl_q;
  logic        wr_n;
  logic [2:0]  err_n;
  logic [31:0] word, len_le;
  logic        is_cb;
  logic [6:0]  bank_num;

  assign dbg_state = state;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  // Headers arrive MSB-first into hdr; the LE length is the byte-reversed view.
  assign word     = {hdr[23:0], ioctl_dout};
  assign len_le   = {ioctl_dout, hdr[7:0], hdr[15:8], hdr[23:16]};
  assign is_cb    = (chk_id[31:16] == "cb") && is_digit(chk_id[15:8]) && is_digit(chk_id[7:0]);
  assign bank_num = 7'(chk_id[11:8]) * 7'd10 + 7'(chk_id[3:0]);

  // Effect of one accepted ioctl byte; the falling-edge check sees the result.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    hdr_n        = hdr;
    chk_id_n     = chk_id;
    chk_len_n    = chk_len;
    remain_n     = remain;
    offset_n     = offset;
    bank_n       = bank;
    exp_n        = exp_addr;
    chunk_seen_n = chunk_seen;
    wr_n         = 1'b0;
    err_n        = 3'd0;
    if (ioctl_wr && state != IDLE && state != ERROR) begin
      if (ioctl_addr != exp_addr) begin
        state_n = ERROR;
        err_n   = 3'd5;
      end else begin
        exp_n = exp_addr + 25'd1;
        hdr_n = word;
        if (state inside {RIFF_ID, RIFF_LEN, FORM, CHK_ID, CHK_LEN})
          cnt_n = cnt + 2'd1;
        case (state)
          RIFF_ID:  if (cnt == 2'd3) begin
                      if (word == "RIFF") state_n = RIFF_LEN;
                      else begin state_n = ERROR; err_n = 3'd1; end
                    end
          RIFF_LEN: if (cnt == 2'd3) state_n = FORM;
          FORM:     if (cnt == 2'd3) begin
                      if (word == "AMS!") state_n = CHK_ID;
                      else begin state_n = ERROR; err_n = 3'd2; end
                    end
          CHK_ID:   if (cnt == 2'd3) begin
                      chk_id_n = word;
                      state_n  = CHK_LEN;
                    end
          CHK_LEN:  if (cnt == 2'd3) begin
                      chk_len_n    = len_le;
                      chunk_seen_n = 1'b1;
                      remain_n     = len_le;
                      offset_n     = 14'd0;
                      if (is_cb) begin
                        if (bank_num >= 7'(MAX_BANKS)) begin
                          state_n = ERROR; err_n = 3'd3;
                        end else if (len_le > 32'(BANK_BYTES)) begin
                          state_n = ERROR; err_n = 3'd4;
                        end else begin
                          bank_n  = bank_num[4:0];
                          state_n = (len_le == 32'd0) ? CHK_ID : DATA;
                        end
                      end else begin
                        state_n = (len_le == 32'd0) ? CHK_ID : SKIP;
                      end
                    end
          DATA:     begin
                      wr_n     = 1'b1;
                      remain_n = remain - 32'd1;
                      offset_n = offset + 14'd1;
                      if (remain == 32'd1) state_n = chk_len[0] ? PAD : CHK_ID;
                    end
          SKIP:     begin
                      remain_n = remain - 32'd1;
                      if (remain == 32'd1) state_n = chk_len[0] ? PAD : CHK_ID;
                    end
          PAD:      state_n = CHK_ID;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      hdr           <= 32'd0;
      chk_id        <= 32'd0;
      chk_len       <= 32'd0;
      remain        <= 32'd0;
      offset        <= 14'd0;
      bank          <= 5'd0;
      exp_addr      <= 25'd0;
      seen          <= 32'd0;
      chunk_seen    <= 1'b0;
      dl_q          <= 1'b0;
      cart_download <= 1'b0;
      cart_addr     <= 25'd0;
      cart_data     <= 8'd0;
      cart_wr       <= 1'b0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      error_code    <= 3'd0;
      bank_count    <= 6'd0;
    end else begin
      dl_q      <= ioctl_download;
      cart_wr   <= 1'b0;
      load_done <= 1'b0;
      if (ioctl_download && !dl_q) begin
        state         <= RIFF_ID;
        cnt           <= 2'd0;
        exp_addr      <= 25'd0;
        seen          <= 32'd0;
        chunk_seen    <= 1'b0;
        load_error    <= 1'b0;
        error_code    <= 3'd0;
        bank_count    <= 6'd0;
        cart_download <= 1'b1;
      end else if (state != IDLE) begin
        state      <= state_n;
        cnt        <= cnt_n;
        hdr        <= hdr_n;
        chk_id     <= chk_id_n;
        chk_len    <= chk_len_n;
        remain     <= remain_n;
        offset     <= offset_n;
        bank       <= bank_n;
        exp_addr   <= exp_n;
        chunk_seen <= chunk_seen_n;
        if (wr_n) begin
          cart_wr   <= 1'b1;
          cart_addr <= {6'd0, bank, offset};
          cart_data <= ioctl_dout;
          if (!seen[bank]) begin
            seen[bank] <= 1'b1;
            bank_count <= bank_count + 6'd1;
          end
        end
        if (err_n != 3'd0) begin
          load_error <= 1'b1;
          error_code <= err_n;
        end
        if (!ioctl_download && dl_q) begin
          state         <= IDLE;
          cart_download <= 1'b0;
          if (state_n != ERROR) begin
            if (state_n == CHK_ID && cnt_n == 2'd0 && chunk_seen_n) begin
              load_done <= 1'b1;
            end else begin
              load_error <= 1'b1;
              error_code <= 3'd6;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gx4000_cpr_loader.sv
// Bench for gx4000_cpr_loader: builds CPR images byte by byte, predicts every
// cartridge write into a queue and checks status outputs at the end of each image.
module tb_gx4000_cpr_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        cart_download;
  logic [24:0] cart_addr;
  logic [7:0]  cart_data;
  logic        cart_wr;
  logic        load_done;
  logic        load_error;
  logic [2:0]  error_code;
  logic [5:0]  bank_count;
  logic [3:0]  dbg_state;

  gx4000_cpr_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .cart_download  (cart_download),
    .cart_addr      (cart_addr),
    .cart_data      (cart_data),
    .cart_wr        (cart_wr),
    .load_done      (load_done),
    .load_error     (load_error),
    .error_code     (error_code),
    .bank_count     (bank_count),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  int          stray_cnt = 0;
  logic [24:0] ptr = 25'd0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every cart_wr must match the head of the expected queue
  always @(negedge clk_sys) begin
    if (load_done) done_cnt++;
    if (cart_wr) begin
      if (exp_q.size() == 0) begin
        stray_cnt++;
      end else begin
        mon_exp = exp_q.pop_front();
        check("cart_wr", {cart_addr, cart_data}, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit drop_dl = 1'b0);
    ioctl_wr   = 1'b1;
    ioctl_addr = ptr;
    ioctl_dout = b;
    ptr        = ptr + 25'd1;
    if (drop_dl) ioctl_download = 1'b0;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic send_id(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_le(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic data_byte(input int bank, input int off, input bit drop_dl = 1'b0);
    logic [7:0]  b;
    logic [24:0] a;
    b = 8'($urandom_range(0, 255));
    a = 25'(bank * 16384 + off);
    exp_q.push_back({a, b});
    send_byte(b, drop_dl);
  endtask

  task automatic junk_bytes(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic start_image();
    ptr            = 25'd0;
    stray_cnt      = 0;
    done_base      = done_cnt;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("dl_active", cart_download, 1);
  endtask

  task automatic riff_hdr();
    send_id("RIFF");
    send_le(32'($urandom_range(100, 60000)));
    send_id("AMS!");
  endtask

  task automatic chunk(input logic [31:0] id, input logic [31:0] len);
    send_id(id);
    send_le(len);
  endtask

  task automatic finish_image(input int e_done, input int e_err, input int e_code, input int e_banks);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("load_done", done_cnt - done_base, e_done);
    check("load_error", load_error, e_err);
    check("error_code", error_code, e_code);
    check("bank_count", bank_count, e_banks);
    check("cart_dl_off", cart_download, 0);
    check("drain", exp_q.size(), 0);
    check("stray_wr", stray_cnt, 0);
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dl"}, cart_download, 0);
    check({tag, "_wr"}, cart_wr, 0);
    check({tag, "_addr"}, cart_addr, 0);
    check({tag, "_data"}, cart_data, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_err"}, load_error, 0);
    check({tag, "_code"}, error_code, 0);
    check({tag, "_banks"}, bank_count, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check_zero("reset");

    // minimal image
    start_image();
    riff_hdr();
    chunk("cb00", 32'd4);
    for (int i = 0; i < 4; i++) data_byte(0, i);
    finish_image(1, 0, 0, 1);

    // odd chunk with pad, second bank, then repeated bank overwrites
    start_image();
    riff_hdr();
    chunk("cb05", 32'd3);
    for (int i = 0; i < 3; i++) data_byte(5, i);
    junk_bytes(1);
    chunk("cb01", 32'd2);
    for (int i = 0; i < 2; i++) data_byte(1, i);
    chunk("cb05", 32'd1);
    data_byte(5, 0);
    junk_bytes(1);
    finish_image(1, 0, 0, 2);

    // bank out of range
    start_image();
    riff_hdr();
    chunk("cb32", 32'd4);
    junk_bytes(4);
    finish_image(0, 1, 3, 0);

    // chunk too long
    start_image();
    riff_hdr();
    chunk("cb00", 32'd16385);
    junk_bytes(6);
    finish_image(0, 1, 4, 0);

    // bad RIFF and bad form
    start_image();
    send_id("RIFX");
    junk_bytes(4);
    finish_image(0, 1, 1, 0);
    start_image();
    send_id("RIFF");
    send_le(32'd64);
    send_id("AMS?");
    finish_image(0, 1, 2, 0);

    // unknown chunk skipped with pad; last byte coincides with download drop
    start_image();
    riff_hdr();
    chunk("fmt ", 32'd5);
    junk_bytes(6);
    chunk("cb00", 32'd2);
    data_byte(0, 0);
    data_byte(0, 1, 1'b1);
    finish_image(1, 0, 0, 1);

    // address gap inside data
    start_image();
    riff_hdr();
    chunk("cb00", 32'd32);
    for (int i = 0; i < 4; i++) data_byte(0, i);
    ptr = ptr + 25'd1;
    junk_bytes(4);
    finish_image(0, 1, 5, 1);

    // truncated mid-data
    start_image();
    riff_hdr();
    chunk("cb02", 32'd8);
    for (int i = 0; i < 3; i++) data_byte(2, i);
    finish_image(0, 1, 6, 1);

    // reset mid-data, then a fresh image
    start_image();
    riff_hdr();
    chunk("cb03", 32'd8);
    for (int i = 0; i < 2; i++) data_byte(3, i);
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b1;
    ioctl_addr     = ptr;
    ioctl_dout     = 8'h5a;
    @(negedge clk_sys);
    reset_n  = 1'b1;
    ioctl_wr = 1'b0;
    check_zero("mid_reset");
    repeat (2) @(negedge clk_sys);
    check("rst_drain", exp_q.size(), 0);
    check("rst_stray", stray_cnt, 0);
    start_image();
    riff_hdr();
    chunk("cb07", 32'd4);
    for (int i = 0; i < 4; i++) data_byte(7, i);
    finish_image(1, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
